pic8259_ctrl: RTL and testbench
===============================

Name: pic8259_ctrl

Overview:
- 8259A-style programmable interrupt controller: accepts 8 interrupt requests (IR0–IR7), raises INT to the CPU, answers a two-pulse 8086-style INTA sequence with an 8-bit vector.
- Sits on the CPU 8-bit data bus as an I/O peripheral (CS/RD/WR/A0).
- Fully synchronous; all bus strobes are sampled on clk and must be held low ≥2 clk cycles.

Parameters:
- none (register layout fixed by 8259A conventions)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cs_n  in  1  chip select, active low
- rd_n  in  1  read strobe, active low
- wr_n  in  1  write strobe, active low
- a0  in  1  register address bit
- data_bus  inout  8  CPU data bus, tri-stated when not driven
- inta_n  in  1  interrupt acknowledge, active low
- int_out  out  1  interrupt request to CPU, active high
- cas  inout  3  cascade ID bus (driven by master, read by slave)
- sp_n  in  1  1 = master, 0 = slave (cascade mode only)
- ir  in  8  interrupt request lines, ir[0] highest priority

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous, active-low.
- Reset values:
  - int_out=0; data_bus and cas = Z.
  - IRR=ISR=IMR=0; ICW regs=0.
  - Init FSM = WAIT_ICW1.
- Write commit: on sampled wr_n rising edge with cs_n=0.
- Init FSM:
  - A0=0 with D4=1 is ICW1 from any state. ICW1 latches IC4=D0, SNGL=D1, LTIM=D3; clears IMR, ISR, IRR and edge history; read select = IRR. Next state WAIT_ICW2.
  - ICW2 (A0=1) stores T7–T3 = D7–D3.
  - Next state is WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
  - ICW3 stores the cascade mask (master) or slave ID D2–D0 (slave).
  - ICW4 stores AEOI=D1 (8086 mode always assumed; no ICW4 ⇒ 8086 mode, AEOI=0).
- READY writes:
  - A0=1: OCW1, IMR ← D.
  - A0=0, D4:D3=00: OCW2. D7:D5=001 is non-specific EOI (clear highest-priority set ISR bit); 011 is specific EOI (clear ISR[D2:D0]); other codes ignored.
  - A0=0, D4:D3=01: OCW3. If D1=1, D0 selects the read register (0=IRR, 1=ISR).
- Reads (cs_n=0, rd_n=0, inta_n=1): A0=0 drives IRR or ISR per OCW3; A0=1 drives IMR.
- Request capture (READY only):
  - Edge mode (LTIM=0): IRR[i] set on ir[i] 0→1 between consecutive clk samples.
  - Level mode: IRR[i] follows ir[i] while not in service.
- Priority: fixed, IR0 highest.
  - int_out=1 when the highest unmasked IRR bit has higher priority than the highest ISR bit (or ISR empty).
- INTA cycle: two pulses; FSM IDLE→ACK1→ACK2→IDLE.
  - First inta_n falling: freeze selected level n; ISR[n]=1; IRR[n]=0; int_out=0.
  - Second pulse: while inta_n=0, drive data_bus={T7..T3, n[2:0]}.
  - Second inta_n rising: release the bus; if AEOI, clear ISR[n].
  - INTA with no pending request: vector level 7.
- Cascade (SNGL=0):
  - Master drives cas=n from first INTA to end of second if ICW3[n]=1, and does not drive data_bus.
  - Slave drives the vector only if cas == its ID.
- Simultaneous events:
  - IR edge during INTA is latched and serviced next.
  - ICW1 write aborts any INTA cycle.
  - rst_n mid-cycle returns everything to reset values on the next clk.

Optional Feature:
- AUTO_EOI_EN
  - Defined: ICW4 D1 (AEOI) is honoured as above.
  - Undefined: AEOI bit ignored; ISR cleared only by OCW2 EOI.

Decomposition:
- Package pic8259_pkg: INTA FSM state enum, init FSM state enum, OCW2 command codes, a priority-encoder function returning {valid, index[2:0]}.
- One natural sub-module: pic8259_prio_resolver (IRR, IMR, ISR → int request + level).

Test Plan:
- ICW1=0x36, ICW2=0xFF, pulse ir=0x08 → int_out=1; two INTA pulses; during second inta_n low data_bus=0xFB; int_out=0 after first pulse; ISR=0x08.
- Same init, OCW1=0x08, ir=0x08 → int_out stays 0; OCW1=0x00 → int_out=1.
- ICW2=0x40, ir=0x24 simultaneously → vector 0x42; OCW2=0x20 (non-specific EOI) → int_out=1; next INTA vector 0x45.
- IR5 in service, IR2 edge → int_out=1 (nesting); IR6 edge with IR5 in service → int_out stays 0 until EOI.
- OCW3=0x0B then read A0=0 → ISR value; OCW3=0x0A → IRR value; read A0=1 → IMR.
- rst_n=0 for one clk between the two INTA pulses → int_out=0, data_bus Z, ISR=0, second pulse ignored until re-init.

Source files
------------

// File: rtl/pic8259_pkg.sv
// Shared constants for the 8259A-style interrupt controller: init/INTA state
// codes, OCW2 command codes and the fixed-priority encoder.
package pic8259_pkg;

    localparam logic [2:0] INIT_WAIT_ICW1 = 3'd0;
    localparam logic [2:0] INIT_WAIT_ICW2 = 3'd1;
    localparam logic [2:0] INIT_WAIT_ICW3 = 3'd2;
    localparam logic [2:0] INIT_WAIT_ICW4 = 3'd3;
    localparam logic [2:0] INIT_READY     = 3'd4;

    localparam logic [1:0] ACK_IDLE = 2'd0;
    localparam logic [1:0] ACK_1    = 2'd1;
    localparam logic [1:0] ACK_2    = 2'd2;

    localparam logic [2:0] OCW2_NS_EOI = 3'b001;
    localparam logic [2:0] OCW2_SP_EOI = 3'b011;

    // Returns {valid, index}; bit 0 is the highest priority.
    function automatic logic [3:0] prio_enc(input logic [7:0] v);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/pic8259_prio_resolver.sv
// Fixed-priority resolver: picks the highest unmasked request and decides
// whether it may interrupt whatever is currently in service.
module pic8259_prio_resolver
    import pic8259_pkg::*;
(
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [7:0] isr,
    output logic       int_req,
    output logic       pending,
    output logic [2:0] level
);

    logic [3:0] req_enc;
    logic [3:0] isr_enc;

    always_comb begin
        req_enc = prio_enc(irr & ~imr);
        isr_enc = prio_enc(isr);
        pending = req_enc[3];
        int_req = req_enc[3] && (!isr_enc[3] || (req_enc[2:0] < isr_enc[2:0]));
        level   = req_enc[3] ? req_enc[2:0] : 3'd7;
    end

endmodule

// File: rtl/pic8259_ctrl.sv
// 8259A-style interrupt controller top: bus interface, init sequence, IRR/ISR/IMR
// and the two-pulse INTA cycle. Define AUTO_EOI_EN to honour the ICW4 AEOI bit.
module pic8259_ctrl
    import pic8259_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    inout  wire  [7:0] data_bus,
    input  logic       inta_n,
    output logic       int_out,
    inout  wire  [2:0] cas,
    input  logic       sp_n,
    input  logic [7:0] ir
);

    logic       wr_n_q, inta_n_q;
    logic [7:0] ir_q;
    logic [7:0] wr_data;
    logic       wr_a0;
    logic [2:0] init_st;
    logic [1:0] ack_st;
    logic       ic4, sngl, ltim, aeoi, rd_isr;
    logic [4:0] t_bits;
    logic [7:0] icw3, irr, isr, imr, irr_nxt, isr_nxt;
    logic [2:0] ack_lvl;
    logic       ack_valid;
    logic       int_req, pending;
    logic [2:0] req_lvl;
    logic [3:0] isr_top;
    logic       ready, wr_commit, icw1_wr, inta_fall, inta_rise, ack_start;
    logic       rd_oe, vec_oe, cas_oe;
    logic [7:0] bus_val;

    pic8259_prio_resolver u_prio (
        .irr     (irr),
        .imr     (imr),
        .isr     (isr),
        .int_req (int_req),
        .pending (pending),
        .level   (req_lvl)
    );

    assign ready     = (init_st == INIT_READY);
    assign wr_commit = !wr_n_q && wr_n && !cs_n;
    assign icw1_wr   = wr_commit && !wr_a0 && wr_data[4];
    assign inta_fall = inta_n_q && !inta_n;
    assign inta_rise = !inta_n_q && inta_n;
    assign ack_start = ready && (ack_st == ACK_IDLE) && inta_fall && !icw1_wr;
    assign isr_top   = prio_enc(isr);

    // Write data is held in a capture register so the commit on the rising
    // strobe does not depend on the CPU still driving the bus.
    always_ff @(posedge clk) begin
        if (!cs_n && !wr_n) begin
            wr_data <= data_bus;
            wr_a0   <= a0;
        end
    end

    always_comb begin
        irr_nxt = irr;
        isr_nxt = isr;
        if (ready) begin
            if (ltim) irr_nxt = (ir & ~isr) | (irr & isr);
            else      irr_nxt = irr | (ir & ~ir_q);
        end
        if (ack_start && pending) begin
            irr_nxt[req_lvl] = 1'b0;
            isr_nxt[req_lvl] = 1'b1;
        end
        if (ready && wr_commit && !wr_a0 && (wr_data[4:3] == 2'b00)) begin
            if (wr_data[7:5] == OCW2_NS_EOI && isr_top[3]) isr_nxt[isr_top[2:0]] = 1'b0;
            if (wr_data[7:5] == OCW2_SP_EOI)               isr_nxt[wr_data[2:0]] = 1'b0;
        end
        if ((ack_st == ACK_2) && inta_rise && aeoi && ack_valid) isr_nxt[ack_lvl] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_n_q    <= 1'b1;
            inta_n_q  <= 1'b1;
            ir_q      <= 8'h00;
            init_st   <= INIT_WAIT_ICW1;
            ack_st    <= ACK_IDLE;
            {ic4, sngl, ltim, aeoi, rd_isr} <= 5'b0;
            t_bits    <= 5'd0;
            icw3      <= 8'h00;
            irr       <= 8'h00;
            isr       <= 8'h00;
            imr       <= 8'h00;
            ack_lvl   <= 3'd0;
            ack_valid <= 1'b0;
        end else begin
            wr_n_q   <= wr_n;
            inta_n_q <= inta_n;
            ir_q     <= ir;
            irr      <= irr_nxt;
            isr      <= isr_nxt;

            if (wr_commit && wr_a0) begin
                case (init_st)
                    INIT_WAIT_ICW2: begin
                        t_bits  <= wr_data[7:3];
                        init_st <= !sngl ? INIT_WAIT_ICW3 : (ic4 ? INIT_WAIT_ICW4 : INIT_READY);
                    end
                    INIT_WAIT_ICW3: begin
                        icw3    <= wr_data;
                        init_st <= ic4 ? INIT_WAIT_ICW4 : INIT_READY;
                    end
                    INIT_WAIT_ICW4: begin
`ifdef AUTO_EOI_EN
                        aeoi    <= wr_data[1];
`else
                        aeoi    <= 1'b0;
`endif
                        init_st <= INIT_READY;
                    end
                    INIT_READY: imr <= wr_data;
                    default: ;
                endcase
            end else if (wr_commit && ready && (wr_data[4:3] == 2'b01) && wr_data[1]) begin
                rd_isr <= wr_data[0];
            end

            case (ack_st)
                ACK_IDLE: if (ack_start) begin
                    ack_st    <= ACK_1;
                    ack_lvl   <= req_lvl;
                    ack_valid <= pending;
                end
                ACK_1:   if (inta_fall) ack_st <= ACK_2;
                ACK_2:   if (inta_rise) ack_st <= ACK_IDLE;
                default: ack_st <= ACK_IDLE;
            endcase

            // ICW1 restarts initialisation and wins over everything above.
            if (icw1_wr) begin
                ic4     <= wr_data[0];
                sngl    <= wr_data[1];
                ltim    <= wr_data[3];
                aeoi    <= 1'b0;
                rd_isr  <= 1'b0;
                icw3    <= 8'h00;
                imr     <= 8'h00;
                isr     <= 8'h00;
                irr     <= 8'h00;
                ir_q    <= 8'hFF;
                ack_st  <= ACK_IDLE;
                init_st <= INIT_WAIT_ICW2;
            end
        end
    end

    assign int_out = ready && (ack_st == ACK_IDLE) && int_req;

    assign rd_oe   = !cs_n && !rd_n && inta_n;
    assign vec_oe  = (ack_st == ACK_2) && !inta_n &&
                     (sngl || (sp_n ? !icw3[ack_lvl] : (cas == icw3[2:0])));
    assign cas_oe  = !sngl && sp_n && (ack_st != ACK_IDLE) && icw3[ack_lvl];
    assign bus_val = rd_oe ? (a0 ? imr : (rd_isr ? isr : irr)) : {t_bits, ack_lvl};

    assign data_bus = (rd_oe || vec_oe) ? bus_val : 8'bz;
    assign cas      = cas_oe ? ack_lvl : 3'bz;

endmodule

// File: tb/tb_pic8259_ctrl.sv
// Self-checking bench for pic8259_ctrl: directed scenarios plus randomized
// traffic checked against a bit-vector model of IRR/ISR/IMR.
module tb_pic8259_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, cs_n, rd_n, wr_n, a0, inta_n, sp_n;
    logic [7:0] ir;
    logic [7:0] tb_data;
    logic       tb_oe;
    wire  [7:0] data_bus;
    wire  [2:0] cas;
    logic       int_out;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_irr, m_isr, m_imr;
    logic [4:0] m_t;

    assign data_bus = tb_oe ? tb_data : 8'bz;
    assign cas      = 3'bz;

    always #5 clk = ~clk;

    pic8259_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (cs_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .a0       (a0),
        .data_bus (data_bus),
        .inta_n   (inta_n),
        .int_out  (int_out),
        .cas      (cas),
        .sp_n     (sp_n),
        .ir       (ir)
    );

    function automatic int highest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic logic exp_int();
        return highest(m_irr & ~m_imr) < highest(m_isr);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic addr, input logic [7:0] d);
        cs_n = 1'b0; a0 = addr; tb_data = d; tb_oe = 1'b1; wr_n = 1'b0;
        tick(2);
        wr_n = 1'b1;
        tick(1);
        cs_n = 1'b1; tb_oe = 1'b0;
        tick(1);
    endtask

    task automatic bus_read(input logic addr, output logic [7:0] d);
        cs_n = 1'b0; a0 = addr; rd_n = 1'b0;
        tick(2);
        d = data_bus;
        rd_n = 1'b1; cs_n = 1'b1;
        tick(1);
    endtask

    task automatic read_isr(output logic [7:0] d);
        bus_write(1'b0, 8'h0B);
        bus_read(1'b0, d);
    endtask

    task automatic read_irr(output logic [7:0] d);
        bus_write(1'b0, 8'h0A);
        bus_read(1'b0, d);
    endtask

    task automatic pulse_ir(input logic [7:0] p);
        ir = p;
        tick(2);
        ir = 8'h00;
        tick(2);
        m_irr = m_irr | p;
    endtask

    task automatic do_inta(output logic int_mid, output logic [7:0] vec);
        inta_n = 1'b0; tick(2);
        int_mid = int_out;
        inta_n = 1'b1; tick(2);
        inta_n = 1'b0; tick(2);
        vec = data_bus;
        inta_n = 1'b1; tick(2);
    endtask

    // Model of one acknowledge: highest unmasked request moves to service.
    task automatic model_inta(output logic [7:0] vec);
        int n;
        n = highest(m_irr & ~m_imr);
        if (n == 8) vec = {m_t, 3'd7};
        else begin
            vec = {m_t, n[2:0]};
            m_isr[n] = 1'b1;
            m_irr[n] = 1'b0;
        end
    endtask

    task automatic init_std(input logic [7:0] icw2);
        bus_write(1'b0, 8'h36);
        bus_write(1'b1, icw2);
        m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_t = icw2[7:3];
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
        tests++;
        if (int_out !== 1'b0) begin fails++; $display("FAIL reset_int got=%b want=0", int_out); end
        bus_read(1'b0, d);
        tests++;
        if (d !== 8'h00) begin fails++; $display("FAIL reset_irr got=%h want=00", d); end
        bus_read(1'b1, d);
        tests++;
        if (d !== 8'h00) begin fails++; $display("FAIL reset_imr got=%h want=00", d); end
    endtask

    task automatic test_basic();
        logic im; logic [7:0] v, d;
        init_std(8'hFF);
        pulse_ir(8'h08);
        tests++;
        if (int_out !== 1'b1) begin fails++; $display("FAIL basic_int got=%b want=1", int_out); end
        do_inta(im, v);
        tests++;
        if (im !== 1'b0) begin fails++; $display("FAIL basic_int_mid got=%b want=0", im); end
        tests++;
        if (v !== 8'hFB) begin fails++; $display("FAIL basic_vec got=%h want=FB", v); end
        read_isr(d);
        tests++;
        if (d !== 8'h08) begin fails++; $display("FAIL basic_isr got=%h want=08", d); end
    endtask

    task automatic test_mask();
        logic [7:0] d;
        init_std(8'hFF);
        bus_write(1'b1, 8'h08);
        pulse_ir(8'h08);
        tests++;
        if (int_out !== 1'b0) begin fails++; $display("FAIL mask_int got=%b want=0", int_out); end
        bus_read(1'b1, d);
        tests++;
        if (d !== 8'h08) begin fails++; $display("FAIL mask_imr got=%h want=08", d); end
        bus_write(1'b1, 8'h00);
        tests++;
        if (int_out !== 1'b1) begin fails++; $display("FAIL unmask_int got=%b want=1", int_out); end
    endtask

    task automatic test_simultaneous();
        logic im; logic [7:0] v;
        init_std(8'h40);
        pulse_ir(8'h24);
        do_inta(im, v);
        tests++;
        if (v !== 8'h42) begin fails++; $display("FAIL simul_vec1 got=%h want=42", v); end
        tests++;
        if (int_out !== 1'b0) begin fails++; $display("FAIL simul_blocked got=%b want=0", int_out); end
        bus_write(1'b0, 8'h20);
        tests++;
        if (int_out !== 1'b1) begin fails++; $display("FAIL simul_eoi_int got=%b want=1", int_out); end
        do_inta(im, v);
        tests++;
        if (v !== 8'h45) begin fails++; $display("FAIL simul_vec2 got=%h want=45", v); end
        bus_write(1'b0, 8'h20);
        do_inta(im, v);
        tests++;
        if (v !== 8'h47) begin fails++; $display("FAIL spurious_vec got=%h want=47", v); end
    endtask

    task automatic test_nesting();
        logic im; logic [7:0] v, d;
        init_std(8'h88);
        pulse_ir(8'h20);
        do_inta(im, v);
        pulse_ir(8'h04);
        tests++;
        if (int_out !== 1'b1) begin fails++; $display("FAIL nest_int got=%b want=1", int_out); end
        do_inta(im, v);
        tests++;
        if (v !== 8'h8A) begin fails++; $display("FAIL nest_vec got=%h want=8A", v); end
        bus_write(1'b0, 8'h62);
        pulse_ir(8'h40);
        tests++;
        if (int_out !== 1'b0) begin fails++; $display("FAIL lower_blocked got=%b want=0", int_out); end
        read_isr(d);
        tests++;
        if (d !== 8'h20) begin fails++; $display("FAIL nest_isr got=%h want=20", d); end
        bus_write(1'b0, 8'h20);
        tests++;
        if (int_out !== 1'b1) begin fails++; $display("FAIL lower_after_eoi got=%b want=1", int_out); end
        do_inta(im, v);
        tests++;
        if (v !== 8'h8E) begin fails++; $display("FAIL nest_vec6 got=%h want=8E", v); end
    endtask

    task automatic test_reads();
        logic im; logic [7:0] v, d;
        init_std(8'h10);
        pulse_ir(8'h12);
        do_inta(im, v);
        bus_write(1'b1, 8'h80);
        read_isr(d);
        tests++;
        if (d !== 8'h02) begin fails++; $display("FAIL read_isr got=%h want=02", d); end
        read_irr(d);
        tests++;
        if (d !== 8'h10) begin fails++; $display("FAIL read_irr got=%h want=10", d); end
        bus_read(1'b1, d);
        tests++;
        if (d !== 8'h80) begin fails++; $display("FAIL read_imr got=%h want=80", d); end
    endtask

    task automatic test_reset_mid_inta();
        logic [7:0] d;
        init_std(8'hFF);
        pulse_ir(8'h08);
        inta_n = 1'b0; tick(2);
        inta_n = 1'b1; tick(2);
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        tests++;
        if (int_out !== 1'b0) begin fails++; $display("FAIL rstmid_int got=%b want=0", int_out); end
        tb_data = 8'h5A; tb_oe = 1'b1;
        inta_n = 1'b0; tick(2);
        tests++;
        if (data_bus !== 8'h5A) begin fails++; $display("FAIL rstmid_bus got=%h want=5A", data_bus); end
        inta_n = 1'b1; tb_oe = 1'b0; tick(2);
        bus_read(1'b0, d);
        tests++;
        if (d !== 8'h00) begin fails++; $display("FAIL rstmid_irr got=%h want=00", d); end
        init_std(8'hFF);
        read_isr(d);
        tests++;
        if (d !== 8'h00) begin fails++; $display("FAIL rstmid_isr got=%h want=00", d); end
    endtask

    task automatic test_aeoi();
        logic im; logic [7:0] v, d, want;
        bus_write(1'b0, 8'h17);
        bus_write(1'b1, 8'h08);
        bus_write(1'b1, 8'h03);
        pulse_ir(8'h01);
        do_inta(im, v);
        tests++;
        if (v !== 8'h08) begin fails++; $display("FAIL aeoi_vec got=%h want=08", v); end
`ifdef AUTO_EOI_EN
        want = 8'h00;
`else
        want = 8'h01;
`endif
        read_isr(d);
        tests++;
        if (d !== want) begin fails++; $display("FAIL aeoi_isr got=%h want=%h", d, want); end
    endtask

    task automatic test_random();
        logic im; logic [7:0] v, ev, d, t;
        int op, l;
        t = 8'($urandom) & 8'hF8;
        init_std(t);
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0, 1: pulse_ir(8'($urandom));
                2: begin
                    if (exp_int()) begin
                        model_inta(ev);
                        do_inta(im, v);
                        tests++;
                        if (v !== ev) begin fails++; $display("FAIL rand_vec it=%0d got=%h want=%h", it, v, ev); end
                    end else begin
                        bus_write(1'b0, 8'h20);
                        l = highest(m_isr);
                        if (l < 8) m_isr[l] = 1'b0;
                    end
                end
                3: begin
                    m_imr = 8'($urandom) & 8'($urandom);
                    bus_write(1'b1, m_imr);
                end
                default: begin
                    l = $urandom_range(0, 7);
                    bus_write(1'b0, 8'h60 | 8'(l));
                    m_isr[l] = 1'b0;
                    read_isr(d);
                    tests++;
                    if (d !== m_isr) begin fails++; $display("FAIL rand_isr it=%0d got=%h want=%h", it, d, m_isr); end
                    read_irr(d);
                    tests++;
                    if (d !== m_irr) begin fails++; $display("FAIL rand_irr it=%0d got=%h want=%h", it, d, m_irr); end
                end
            endcase
            tests++;
            if (int_out !== exp_int()) begin
                fails++;
                $display("FAIL rand_int it=%0d got=%b want=%b", it, int_out, exp_int());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0;
        inta_n = 1'b1; sp_n = 1'b1; ir = 8'h00; tb_data = 8'h00; tb_oe = 1'b0;
        m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_t = 5'd0;
        test_reset();
        test_basic();
        test_mask();
        test_simultaneous();
        test_nesting();
        test_reads();
        test_reset_mid_inta();
        test_aeoi();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
